msrv32_instr_fetch_queue: RTL and testbench
===========================================

MSRV32_INSTR_FETCH_QUEUE -- requirements
Module: msrv32_instr_fetch_queue

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000: fetch PC after reset.
REQ-002 Parameter DEPTH, default 4: queue entries, power of two, 2..8.
REQ-003 clk_in  input  1: single clock, all state on rising edge.
REQ-004 rst_in  input  1: reset, synchronous, active-high.
REQ-005 imem_req_out  output  1: instruction-memory read request.
REQ-006 imem_addr_out  output  32: read address, word-aligned.
REQ-007 imem_ack_in  input  1: read data valid this cycle; ends the request.
REQ-008 imem_rdata_in  input  32: fetched instruction word.
REQ-009 redirect_in  input  1: branch, jump or trap redirect; discards everything fetched so far.
REQ-010 redirect_pc_in  input  32: new fetch PC; bits[1:0] are forced to 0.
REQ-011 stall_in  input  1: decode stage holds the current head entry.
REQ-012 instr_out  output  32: head instruction, or 32'h0000_0013 (NOP) when the queue is empty.
REQ-013 pc_out  output  32: PC of the head entry, or 0 when the queue is empty.
REQ-014 instr_valid_out  output  1: head entry is valid.
REQ-015 flush_out  output  1: drives the decoder flush input so decode injects a NOP.

Function
REQ-016 Storage: circular FIFO of DEPTH {pc, instr} entries with read pointer, write pointer and count (0..DEPTH).
REQ-017 FSM states:
- IDLE: no request.
- REQ: request outstanding.
- DROP: outstanding request whose data is to be discarded.
REQ-018 imem_req_out is 1 in REQ and DROP, 0 in IDLE.
REQ-019 imem_addr_out comes from a separate address register; it is loaded on entry to REQ and held stable until imem_ack_in.
REQ-020 IDLE->REQ when count_next < DEPTH and redirect_in=0. The request carries fetch_pc.
REQ-021 REQ with ack and no redirect:
- push {fetch_pc, imem_rdata_in};
- fetch_pc += 4 (mod 2^32);
- go to REQ with the new address if count_next < DEPTH, else go to IDLE.
REQ-022 REQ without ack: hold state and address.
REQ-023 Pop when instr_valid_out=1, stall_in=0 and redirect_in=0. Push and pop in the same cycle leave count unchanged.
REQ-024 Redirect has priority over push, pop and FSM:
- clear the queue (count=0, pointers equal);
- fetch_pc <= {redirect_pc_in[31:2], 2'b00}.
REQ-025 Redirect in REQ without ack: go to DROP. The address is held.
REQ-026 Redirect in REQ with ack, or in IDLE: the ack data is discarded; go to IDLE.
REQ-027 DROP: on ack, discard the data and go to IDLE. A further redirect in DROP only updates fetch_pc.
REQ-028 Never push when count=DEPTH. The REQ issue rule guarantees this. Push when full is an assertion failure.
REQ-029 instr_valid_out = (count != 0).
REQ-030 flush_out = rst_in | redirect_in | (count == 0).
REQ-031 Fetch-to-output latency: data acked in cycle N appears on instr_out in cycle N+1 when the queue was empty.

Reset
REQ-032 While rst_in=1 at a clock edge:
- state=IDLE, count=0, pointers=0, fetch_pc=BOOT_ADDR, address register=BOOT_ADDR.
REQ-033 Outputs after reset: imem_req_out=0, instr_valid_out=0, instr_out=32'h0000_0013, pc_out=0, flush_out=1.
REQ-034 Reset mid-request abandons the outstanding access with no DROP. The memory model is reset together with this block.
REQ-035 The first request is asserted in the cycle after rst_in deasserts, with imem_addr_out=BOOT_ADDR.

Verification
REQ-036 Reset release, ack one cycle after each request, stall_in=0:
- addresses 0, 4, 8, ...;
- instr_out follows rdata with pc_out 0, 4, 8;
- flush_out=0 from the first valid cycle.
REQ-037 stall_in=1 held, ack every cycle, DEPTH=4:
- four entries pushed, then imem_req_out=0;
- release stall -> one pop per cycle and requests resume.
REQ-038 Redirect to 32'h0000_0103 while REQ is waiting for ack:
- DROP entered, same address held until ack, data dropped;
- next request at 32'h0000_0100, flush_out=1 until the first new entry.
REQ-039 Redirect in the same cycle as an ack:
- no push;
- queue empty next cycle, instr_out=32'h0000_0013.
REQ-040 fetch_pc=32'hFFFF_FFFC acked -> next address 32'h0000_0000 (wrap-around).
REQ-041 rst_in asserted while the queue holds 3 entries and a request is outstanding:
- next cycle count=0, imem_req_out=0, flush_out=1;
- first request after release at BOOT_ADDR.

Source files
------------

// File: rtl/msrv32_instr_fetch_queue.sv
// Instruction fetch queue: issues word reads to instruction memory and buffers
// fetched {pc, instr} pairs for decode; a redirect discards everything in flight.

module msrv32_instr_fetch_queue_chk (
   input logic clk,
   input logic rst,
   input logic push,
   input logic full
);
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

module msrv32_instr_fetch_queue #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ack_in,
   input  logic [31:0] imem_rdata_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   input  logic        stall_in,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid_out,
   output logic        flush_out
);
   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]     NOP_C   = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

   state_t        state_r;
   logic [31:0]   fetch_pc_r;
   logic [31:0]   addr_r;
   logic [31:0]   pc_mem_r    [DEPTH];
   logic [31:0]   instr_mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic          push_s;
   logic          pop_s;
   logic          empty_s;
   logic          full_s;
   logic [31:0]   fetch_pc_inc_s;
   logic [1:0]    unused_pc_lsb_s;

   assign unused_pc_lsb_s = redirect_pc_in[1:0];

   // Push/pop decisions and the occupancy the queue will have after this edge
   always_comb begin
      empty_s        = (count_r == {CW{1'b0}});
      full_s         = (count_r == DEPTH_C);
      pop_s          = !empty_s && !stall_in && !redirect_in;
      push_s         = (state_r == REQ) && imem_ack_in && !redirect_in;
      fetch_pc_inc_s = fetch_pc_r + 32'd4;
      count_next_s   = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1'b1);
         2'b01:   count_next_s = count_r - CW'(1'b1);
         default: count_next_s = count_r;
      endcase
   end

   // Entry storage; unreset because occupancy alone decides what is visible
   always_ff @(posedge clk_in) begin
      if (push_s && !rst_in) begin
         pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
         instr_mem_r[wr_ptr_r] <= imem_rdata_in;
      end
   end

   // Request FSM, fetch PC, address register and queue pointers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r    <= IDLE;
         fetch_pc_r <= BOOT_ADDR;
         addr_r     <= BOOT_ADDR;
         rd_ptr_r   <= {PW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
      end else if (redirect_in) begin
         rd_ptr_r   <= wr_ptr_r;
         count_r    <= {CW{1'b0}};
         fetch_pc_r <= {redirect_pc_in[31:2], 2'b00};
         // An unanswered request must still complete, so its data is dropped later
         case (state_r)
            REQ:     state_r <= imem_ack_in ? IDLE : DROP;
            DROP:    state_r <= imem_ack_in ? IDLE : DROP;
            default: state_r <= IDLE;
         endcase
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
         count_r <= count_next_s;
         case (state_r)
            IDLE: begin
               if (count_next_s < DEPTH_C) begin
                  state_r <= REQ;
                  addr_r  <= fetch_pc_r;
               end
            end
            REQ: begin
               if (imem_ack_in) begin
                  fetch_pc_r <= fetch_pc_inc_s;
                  if (count_next_s < DEPTH_C) begin
                     state_r <= REQ;
                     addr_r  <= fetch_pc_inc_s;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            DROP: begin
               if (imem_ack_in) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign imem_req_out    = (state_r != IDLE);
   assign imem_addr_out   = addr_r;
   assign instr_valid_out = !empty_s;
   assign instr_out       = empty_s ? NOP_C : instr_mem_r[rd_ptr_r];
   assign pc_out          = empty_s ? 32'h0000_0000 : pc_mem_r[rd_ptr_r];
   assign flush_out       = rst_in | redirect_in | empty_s;

   msrv32_instr_fetch_queue_chk u_chk (
      .clk  (clk_in),
      .rst  (rst_in),
      .push (push_s),
      .full (full_s)
   );
endmodule

// File: tb/tb_msrv32_instr_fetch_queue.sv
// Bench for the fetch queue: directed scenarios plus random traffic checked
// against a queue-based reference model of the fetch/request rules.

module tb_msrv32_instr_fetch_queue;
   localparam logic [31:0] BOOT = 32'h0000_0000;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall = 1'b0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;
   logic        flush;

   int errors = 0;
   int checks = 0;

   typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
   ent_t        mq[$];
   logic        m_busy = 1'b0;
   logic        m_drop = 1'b0;
   logic [31:0] m_addr = BOOT;
   logic [31:0] m_fetch = BOOT;

   msrv32_instr_fetch_queue #(.BOOT_ADDR(BOOT), .DEPTH(DEPTH)) dut (
      .clk_in(clk), .rst_in(rst), .imem_req_out(imem_req), .imem_addr_out(imem_addr),
      .imem_ack_in(imem_ack), .imem_rdata_in(imem_rdata), .redirect_in(redirect),
      .redirect_pc_in(redirect_pc), .stall_in(stall), .instr_out(instr), .pc_out(pc),
      .instr_valid_out(valid), .flush_out(flush)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; memory only answers an outstanding request
   task automatic drive(input logic r, input logic rd, input logic [31:0] rpc,
                        input logic st, input logic ak, input logic [31:0] rdat);
      @(negedge clk);
      rst = r; redirect = rd; redirect_pc = rpc; stall = st;
      imem_ack = ak && m_busy; imem_rdata = rdat;
      #1;
   endtask

   // Advance the reference model across one rising edge
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         mq.delete(); m_busy = 1'b0; m_drop = 1'b0; m_fetch = BOOT; m_addr = BOOT;
      end else if (redirect) begin
         mq.delete();
         m_fetch = {redirect_pc[31:2], 2'b00};
         if (m_busy && !imem_ack) m_drop = 1'b1;
         else begin m_busy = 1'b0; m_drop = 1'b0; end
      end else begin
         if (mq.size() > 0 && !stall) void'(mq.pop_front());
         if (m_busy && m_drop) begin
            if (imem_ack) begin m_busy = 1'b0; m_drop = 1'b0; end
         end else if (m_busy) begin
            if (imem_ack) begin
               mq.push_back('{m_fetch, imem_rdata});
               m_fetch = m_fetch + 32'd4;
               if (mq.size() < DEPTH) m_addr = m_fetch;
               else m_busy = 1'b0;
            end
         end else if (mq.size() < DEPTH) begin
            m_busy = 1'b1; m_addr = m_fetch;
         end
      end
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
      checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL reset_flush got=%0b exp=1", flush); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL release_req got=%0b exp=0", imem_req); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL release_flush got=%0b exp=1", flush); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%0b exp=1", imem_req); end
      checks++; if (imem_addr !== BOOT) begin errors++; $display("FAIL first_addr got=%h exp=%h", imem_addr, BOOT); end
      tick();
   endtask

   task automatic test_sequential();
      int nack = 0;
      int nvalid = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, $urandom);
         if (m_busy) begin
            checks++;
            if (imem_addr !== 32'(nack * 4)) begin errors++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, 32'(nack * 4)); end
         end
         checks++;
         if (valid !== (mq.size() != 0)) begin errors++; $display("FAIL seq_valid got=%0b exp=%0b", valid, mq.size() != 0); end
         checks++;
         if (flush !== (mq.size() == 0)) begin errors++; $display("FAIL seq_flush got=%0b exp=%0b", flush, mq.size() == 0); end
         if (mq.size() != 0) begin
            checks++;
            if (pc !== 32'(nvalid * 4) || instr !== mq[0].instr) begin
               errors++; $display("FAIL seq_head got=%h/%h exp=%h/%h", pc, instr, 32'(nvalid * 4), mq[0].instr);
            end
            nvalid++;
         end
         if (imem_ack) nack++;
         tick();
      end
   endtask

   task automatic test_stall_full();
      int nack = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, $urandom);
         if (imem_ack) nack++;
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checks++; if (nack != 4) begin errors++; $display("FAIL full_pushes got=%0d exp=4", nack); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got=%0b exp=0", imem_req); end
      checks++; if (valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL full_head got=%0b/%h exp=1/0", valid, pc); end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, $urandom);
         checks++;
         if (pc !== 32'(i * 4)) begin errors++; $display("FAIL drain_pc got=%h exp=%h", pc, 32'(i * 4)); end
         if (i >= 1) begin
            checks++;
            if (imem_req !== 1'b1) begin errors++; $display("FAIL resume_req got=%0b exp=1", imem_req); end
         end
         tick();
      end
   endtask

   task automatic test_redirect_drop();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0000);
      tick();
      drive(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0);
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_flush got=%0b exp=1", flush); end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0004) begin
            errors++; $display("FAIL drop_hold got=%0b/%h exp=1/00000004", imem_req, imem_addr);
         end
         checks++; if (valid !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL drop_empty got=%0b/%0b exp=0/1", valid, flush); end
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL drop_discard got=%0b/%0b exp=0/0", imem_req, valid); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
      checks++; if (imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_addr got=%h exp=00000100", imem_addr); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_flush_wait got=%0b exp=1", flush); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (valid !== 1'b1 || pc !== 32'h0000_0100 || instr !== 32'h1234_5678 || flush !== 1'b0) begin
         errors++; $display("FAIL redir_entry got=%0b/%h/%h/%0b exp=1/00000100/12345678/0", valid, pc, instr, flush);
      end
      tick();
   endtask

   task automatic test_redirect_ack();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_ABCD);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL redir_ack got=%0b/%h/%h/%0b exp=0/%h/0/0", valid, instr, pc, imem_req, NOP);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL redir_ack_next got=%0b/%h exp=1/00000200", imem_req, imem_addr); end
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0BAD_F00D);
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got=%0b/%h exp=1/00000000", imem_req, imem_addr); end
      checks++; if (pc !== 32'hFFFF_FFFC || instr !== 32'h0BAD_F00D) begin errors++; $display("FAIL wrap_head got=%h/%h exp=fffffffc/0badf00d", pc, instr); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1, (i != 0), $urandom);
         tick();
      end
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || valid !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL pre_reset got=%0b/%0b/%0b exp=1/1/1", imem_req, valid, flush); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b0 || valid !== 1'b0 || flush !== 1'b1) begin
         errors++; $display("FAIL mid_reset got=%0b/%0b/%0b exp=0/0/1", imem_req, valid, flush);
      end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== BOOT) begin errors++; $display("FAIL mid_reset_req got=%0b/%h exp=1/%h", imem_req, imem_addr, BOOT); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(63) == 0, $urandom_range(9) == 0, $urandom,
               $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom);
         e_instr = (mq.size() != 0) ? mq[0].instr : NOP;
         e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
         checks++;
         if (imem_req !== m_busy || (m_busy && imem_addr !== m_addr)) begin
            errors++; $display("FAIL rnd_req cyc=%0d got=%0b/%h exp=%0b/%h", i, imem_req, imem_addr, m_busy, m_addr);
         end
         checks++;
         if (valid !== (mq.size() != 0) || instr !== e_instr || pc !== e_pc) begin
            errors++; $display("FAIL rnd_head cyc=%0d got=%0b/%h/%h exp=%0b/%h/%h", i, valid, instr, pc, mq.size() != 0, e_instr, e_pc);
         end
         checks++;
         if (flush !== (rst || redirect || mq.size() == 0)) begin
            errors++; $display("FAIL rnd_flush cyc=%0d got=%0b exp=%0b", i, flush, rst || redirect || mq.size() == 0);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall_full();
      test_redirect_drop();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
